gnrl_rr_arb_stage: RTL and testbench



---
 rtl/gnrl_rr_arb_stage.sv | 81 ++++++++
 tb/tb_gnrl_rr_arb_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gnrl_rr_arb_stage.sv
// N-way round-robin arbiter feeding a single registered valid/ready output stage.
// The grant search starts at the requester after the last one accepted.
module gnrl_rr_arb_stage #(
  parameter int N   = 4,
  parameter int DW  = 32,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    i_vld,
  output logic [N-1:0]    i_rdy,
  input  logic [N*DW-1:0] i_dat,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [DW-1:0]   o_dat,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;
  logic           stg_en;
  logic           found;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   gnt;
  logic           in_hs;
  logic [DW-1:0]  sel_dat;
  logic [DW-1:0]  dat_arr [N];
  logic [IDW:0]   cand    [N];

  // cand[gi] is the requester index visited at search position gi, i.e. (ptr + gi) mod N
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_req
      logic [IDW:0] sum;
      assign sum          = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign cand[gi]     = (sum >= (IDW+1)'(N)) ? (sum - (IDW+1)'(N)) : sum;
      assign dat_arr[gi]  = i_dat[gi*DW +: DW];
      assign gnt[gi]      = found && (gnt_id == IDW'(gi));
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int off = 0; off < N; off++) begin
      if (!found && i_vld[cand[off][IDW-1:0]]) begin
        found  = 1'b1;
        gnt_id = cand[off][IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) sel_dat |= dat_arr[k];
    end
  end

  // rst_n gates ready so no handshake is seen while reset is held
  assign stg_en   = ~o_vld | o_rdy;
  assign i_rdy    = gnt & {N{stg_en & rst_n}};
  assign in_hs    = |i_rdy;
  assign ptr_next = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld   <= 1'b0;
      o_dat   <= '0;
      o_id    <= '0;
      ptr_reg <= '0;
    end else if (in_hs) begin
      o_vld   <= 1'b1;
      o_dat   <= sel_dat;
      o_id    <= gnt_id;
      ptr_reg <= ptr_next;
    end else if (o_rdy) begin
      o_vld   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gnrl_rr_arb_stage.sv
// Directed bench for gnrl_rr_arb_stage: vector table for steady-state arbitration,
// hand-written sequences for reset and mid-operation reset.
module tb_gnrl_rr_arb_stage;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    i_vld;
  logic [N-1:0]    i_rdy;
  logic [N*DW-1:0] i_dat;
  logic            o_vld;
  logic            o_rdy;
  logic [DW-1:0]   o_dat;
  logic [IDW-1:0]  o_id;

  int checks;
  int failures;

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ovld;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs [21];

  gnrl_rr_arb_stage #(.N(N), .DW(DW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .o_id  (o_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pay(input int k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] er,
                              input logic eo, input logic [1:0] ei);
    vec_t t;
    t.vld = v; t.ordy = r; t.exp_rdy = er; t.exp_ovld = eo; t.exp_id = ei;
    return t;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < N; k++) i_dat[k*DW +: DW] = pay(k);

    // round robin over all four, backpressure, wrap-around, single requester, empty-stage load
    vecs[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    vecs[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    vecs[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    vecs[5]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[6]  = mk(4'b1110, 1'b0, 4'b0000, 1'b1, 2'd1);
    vecs[7]  = mk(4'b1110, 1'b0, 4'b0000, 1'b1, 2'd1);
    vecs[8]  = mk(4'b1110, 1'b0, 4'b0000, 1'b1, 2'd1);
    vecs[9]  = mk(4'b1110, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[10] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[11] = mk(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    vecs[12] = mk(4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[13] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[14] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    vecs[15] = mk(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);
    vecs[16] = mk(4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3);
    vecs[17] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    vecs[18] = mk(4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
    vecs[19] = mk(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1);
    vecs[20] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);

    // reset with all requests pending
    rst_n = 1'b0;
    i_vld = 4'b1111;
    o_rdy = 1'b1;
    #2;
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_o_dat", o_dat, 32'd0);
    chk("rst_o_id",  32'(o_id), 32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_o_vld", 32'(o_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      i_vld = vecs[i].vld;
      o_rdy = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_i_rdy", i), 32'(i_rdy), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_o_vld", i), 32'(o_vld), 32'(vecs[i].exp_ovld));
      if (vecs[i].exp_ovld) begin
        chk($sformatf("v%0d_o_id", i), 32'(o_id), 32'(vecs[i].exp_id));
        chk($sformatf("v%0d_o_dat", i), o_dat, pay(int'(vecs[i].exp_id)));
      end
      $display("vec %0d i_vld=%b o_rdy=%b i_rdy=%b o_vld=%b o_id=%0d o_dat=%h",
               i, vecs[i].vld, vecs[i].ordy, i_rdy, o_vld, o_id, o_dat);
      @(negedge clk);
    end

    // mid-operation reset: load a beat from requester 2 (ptr is 2 here), stall, then reset
    i_vld = 4'b0100;
    o_rdy = 1'b0;
    @(posedge clk); #1;
    chk("mr_load_o_vld", 32'(o_vld), 32'd1);
    chk("mr_load_o_id",  32'(o_id), 32'd2);
    @(negedge clk);
    i_vld = 4'b1111;
    o_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_async_o_vld", 32'(o_vld), 32'd0);
    chk("mr_async_i_rdy", 32'(i_rdy), 32'd0);
    $display("midreset o_vld=%b i_rdy=%b", o_vld, i_rdy);
    @(negedge clk);
    rst_n = 1'b1;
    i_vld = 4'b0000;
    o_rdy = 1'b1;
    @(posedge clk); #1;
    chk("mr_after_o_vld", 32'(o_vld), 32'd0);
    @(negedge clk);
    i_vld = 4'b1111;
    #1;
    chk("mr_ptr0_i_rdy", 32'(i_rdy), 32'b0001);
    @(posedge clk); #1;
    chk("mr_ptr0_o_vld", 32'(o_vld), 32'd1);
    chk("mr_ptr0_o_id",  32'(o_id), 32'd0);
    chk("mr_ptr0_o_dat", o_dat, pay(0));
    $display("postreset o_vld=%b o_id=%0d o_dat=%h", o_vld, o_id, o_dat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
